// File: rtl/axi_r_beat_gen.sv
// Purpose : AXI slave read-data generator; turns one AR command at a time into SRAM word reads and R packets.
// Latency : AR handshake in cycle 0, mem_cs in cycle 1, SRAM data captured end of cycle 2, r_valid in cycle 3.
// Backpress: 2-entry output buffer; a read is issued only if buffered + in-flight beats stay <= 2, so 1 beat/cycle.
//
// Ports: clk/rst_n (async active-low); ar_* command in (ar_ready registered, high in IDLE);
//        mem_cs/mem_addr/mem_rdata to a 1-cycle-latency SRAM; r_pkt/r_valid/r_ready towards the R FIFO.
//        r_pkt = {rid, rdata[31:0], rresp[1:0], rlast}.
// Option : define AXI_R_DECERR_EN to answer commands with ar_addr[31:ADDR_W+2] != 0 as DECERR
//          (no SRAM access, rdata=0, rresp=2'b11). Undefined: upper address bits alias.
module axi_r_beat_gen #(
  parameter int ADDR_W = 10,
  parameter int ID_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [31:0]       ar_addr,
  input  logic [3:0]        ar_len,
  input  logic [1:0]        ar_burst,
  output logic              mem_cs,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [ID_W+34:0]  r_pkt,
  output logic              r_valid,
  input  logic              r_ready
);

  localparam int AW    = ADDR_W + 2;   // byte-address width covered by the SRAM
  localparam int PKT_W = ID_W + 35;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  // Command registers
  state_t            state_q;
  logic [ID_W-1:0]   id_q;
  logic [AW-1:0]     addr_q;
  logic [3:0]        len_q;
  logic [1:0]        burst_q;
  logic [3:0]        cnt_q;
  logic              err_q;

  // Beat in flight through the SRAM (issued last cycle, data arrives this cycle)
  logic              infl_vld;
  logic              infl_last;
  logic              infl_err;
  logic [ID_W-1:0]   infl_id;

  // Output buffer
  logic [PKT_W-1:0]  buf_q [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ_q;

  logic              pop;
  logic [2:0]        credit;
  logic              issue;
  logic              last_issue;
  logic              addr_err;
  logic              wrap_legal;
  logic [AW-1:0]     wrap_mask;
  logic [AW-1:0]     addr_inc;
  logic [AW-1:0]     next_addr;
  logic [PKT_W-1:0]  cap_pkt;
  logic              unused_addr_bits;

`ifdef AXI_R_DECERR_EN
  assign addr_err = |ar_addr[31:AW];
`else
  assign addr_err = 1'b0;
`endif

  // Word transfers only: byte-lane bits are dropped; upper bits only matter for DECERR.
  assign unused_addr_bits = ^{ar_addr[31:AW], ar_addr[1:0]};

  assign pop = r_valid & r_ready;

  // Beats that will still hold a buffer slot after this cycle's pop. Keeping this
  // below 2 at issue time guarantees the SRAM return always finds a free entry.
  assign credit     = {1'b0, occ_q} + {2'b00, infl_vld} - {2'b00, pop};
  assign issue      = (state_q == S_BURST) && (credit < 3'd2);
  assign last_issue = (cnt_q == len_q);

  // DECERR beats follow the same issue/credit path but never touch the SRAM.
  assign mem_cs   = issue & ~err_q;
  assign mem_addr = addr_q[AW-1:2];

  // Burst address sequencing
  assign wrap_legal = (burst_q == 2'b10) &&
                      ((len_q == 4'd1) || (len_q == 4'd3) || (len_q == 4'd7) || (len_q == 4'd15));
  assign wrap_mask  = AW'({len_q, 2'b11});     // container size - 1, in bytes
  assign addr_inc   = addr_q + AW'(4);

  always_comb begin
    next_addr = addr_inc;                     // INCR, reserved 2'b11, and illegal-len WRAP
    if (burst_q == 2'b00) begin
      next_addr = addr_q;
    end else if (wrap_legal) begin
      next_addr = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
    end
  end

  // Command FSM. No drain state: buffered beats keep flowing while the next AR is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ar_ready <= 1'b1;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      burst_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ar_valid) begin
            id_q     <= ar_id;
            addr_q   <= {ar_addr[AW-1:2], 2'b00};
            len_q    <= ar_len;
            burst_q  <= ar_burst;
            cnt_q    <= '0;
            err_q    <= addr_err;
            state_q  <= S_BURST;
            ar_ready <= 1'b0;
          end
        end
        S_BURST: begin
          if (issue) begin
            addr_q <= next_addr;
            cnt_q  <= cnt_q + 4'd1;
            if (last_issue) begin
              state_q  <= S_IDLE;
              ar_ready <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          ar_ready <= 1'b1;
        end
      endcase
    end
  end

  // Sideband travels with the read so a new AR landing in id_q cannot corrupt it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_vld  <= 1'b0;
      infl_last <= 1'b0;
      infl_err  <= 1'b0;
      infl_id   <= '0;
    end else begin
      infl_vld <= issue;
      if (issue) begin
        infl_last <= last_issue;
        infl_err  <= err_q;
        infl_id   <= id_q;
      end
    end
  end

  assign cap_pkt = {infl_id,
                    infl_err ? 32'h0 : mem_rdata,
                    infl_err ? 2'b11 : 2'b00,
                    infl_last};

  // 2-entry ring; the head entry is only replaced after it is popped, so r_pkt
  // holds steady across stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (infl_vld) begin
        buf_q[wr_ptr] <= cap_pkt;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ_q <= occ_q + {1'b0, infl_vld} - {1'b0, pop};
    end
  end

  assign r_valid = (occ_q != 2'd0);
  assign r_pkt   = buf_q[rd_ptr];

endmodule

// File: tb/tb_axi_r_beat_gen.sv
module tb_axi_r_beat_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ar_valid;
  logic        ar_ready;
  logic [6:0]  ar_id;
  logic [31:0] ar_addr;
  logic [3:0]  ar_len;
  logic [1:0]  ar_burst;
  logic        mem_cs;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic [41:0] r_pkt;
  logic        r_valid;
  logic        r_ready;

  int checks = 0;
  int errors = 0;

  axi_r_beat_gen #(.ADDR_W(10), .ID_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ar_valid  (ar_valid),
    .ar_ready  (ar_ready),
    .ar_id     (ar_id),
    .ar_addr   (ar_addr),
    .ar_len    (ar_len),
    .ar_burst  (ar_burst),
    .mem_cs    (mem_cs),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .r_pkt     (r_pkt),
    .r_valid   (r_valid),
    .r_ready   (r_ready)
  );

  always #5 clk = ~clk;

  // SRAM preloaded with mem[i] = A000_0000 + i, one-cycle read latency
  always @(posedge clk) begin
    if (mem_cs) mem_rdata <= 32'hA000_0000 + {22'd0, mem_addr};
  end

  // Monitor
  logic [41:0] pkt_q[$];
  int          cyc_q[$];
  int          cyc = 0;
  int          issued = 0, popped = 0;
  int          credit_err = 0, stall_err = 0, stall_seen = 0, cs_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [41:0] prev_pkt = '0;
  int          hs_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      issued     <= 0;
      popped     <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (mem_cs) begin
        issued <= issued + 1;
        cs_cnt <= cs_cnt + 1;
      end
      if (r_valid && r_ready) begin
        popped <= popped + 1;
        pkt_q.push_back(r_pkt);
        cyc_q.push_back(cyc);
      end
      if ((issued + int'(mem_cs)) - (popped + int'(r_valid && r_ready)) > 2)
        credit_err <= credit_err + 1;
      if (prev_stall && (!r_valid || r_pkt !== prev_pkt))
        stall_err <= stall_err + 1;
      if (r_valid && !r_ready) stall_seen <= stall_seen + 1;
      prev_stall <= r_valid && !r_ready;
      prev_pkt   <= r_pkt;
    end
  end

  function automatic logic [41:0] mk(input logic [6:0] id, input logic [31:0] d,
                                     input logic [1:0] resp, input logic last);
    return {id, d, resp, last};
  endfunction

  task automatic send_ar(input logic [6:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
    int t = 0;
    @(negedge clk);
    while (!ar_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (ar_ready !== 1'b1) begin
      errors++;
      $display("FAIL ar_ready timeout: got %b expected 1", ar_ready);
    end
    ar_valid = 1'b1;
    ar_id    = id;
    ar_addr  = addr;
    ar_len   = len;
    ar_burst = burst;
    hs_cyc   = cyc;
    @(posedge clk);
    #1 ar_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string name);
    int t = 0;
    while (pkt_q.size() < n && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (6) @(posedge clk);
    checks++;
    if (pkt_q.size() != n) begin
      errors++;
      $display("FAIL %s beat count: got %0d expected %0d", name, pkt_q.size(), n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks += 5;
    if (ar_ready !== 1'b1) begin errors++; $display("FAIL reset ar_ready: got %b expected 1", ar_ready); end
    if (r_valid !== 1'b0)  begin errors++; $display("FAIL reset r_valid: got %b expected 0", r_valid); end
    if (r_pkt !== 42'h0)   begin errors++; $display("FAIL reset r_pkt: got %h expected 0", r_pkt); end
    if (mem_cs !== 1'b0)   begin errors++; $display("FAIL reset mem_cs: got %b expected 0", mem_cs); end
    if (mem_addr !== 10'h0) begin errors++; $display("FAIL reset mem_addr: got %h expected 0", mem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_incr;
    logic [41:0] exp;
    pkt_q.delete(); cyc_q.delete();
    send_ar(7'd5, 32'h10, 4'd3, 2'b01);
    @(negedge clk);
    checks++;
    if (mem_cs !== 1'b1 || mem_addr !== 10'd4 || r_valid !== 1'b0) begin
      errors++;
      $display("FAIL incr first issue: got cs=%b addr=%h rv=%b expected cs=1 addr=004 rv=0",
               mem_cs, mem_addr, r_valid);
    end
    wait_beats(4, "incr");
    for (int i = 0; i < 4; i++) begin
      exp = mk(7'd5, 32'hA000_0004 + i, 2'b00, i == 3);
      checks++;
      if (i >= pkt_q.size() || pkt_q[i] !== exp) begin
        errors++;
        $display("FAIL incr beat%0d: got %h expected %h", i,
                 (i < pkt_q.size()) ? pkt_q[i] : 42'h0, exp);
      end
    end
    checks++;
    if (cyc_q.size() < 4 || cyc_q[0] != hs_cyc + 3 || cyc_q[3] != hs_cyc + 6) begin
      errors++;
      $display("FAIL incr timing: got first=%0d last=%0d expected %0d..%0d",
               (cyc_q.size() > 0) ? cyc_q[0] - hs_cyc : -1,
               (cyc_q.size() > 3) ? cyc_q[3] - hs_cyc : -1, 3, 6);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] words [4] = '{32'hA000_0002, 32'hA000_0003, 32'hA000_0000, 32'hA000_0001};
    logic [41:0] exp;
    pkt_q.delete(); cyc_q.delete();
    send_ar(7'd9, 32'h08, 4'd3, 2'b10);
    wait_beats(4, "wrap");
    for (int i = 0; i < 4; i++) begin
      exp = mk(7'd9, words[i], 2'b00, i == 3);
      checks++;
      if (i >= pkt_q.size() || pkt_q[i] !== exp) begin
        errors++;
        $display("FAIL wrap beat%0d: got %h expected %h", i,
                 (i < pkt_q.size()) ? pkt_q[i] : 42'h0, exp);
      end
    end
  endtask

  task automatic test_fixed_single;
    logic [41:0] exp;
    pkt_q.delete(); cyc_q.delete();
    send_ar(7'd3, 32'h20, 4'd2, 2'b00);
    wait_beats(3, "fixed");
    for (int i = 0; i < 3; i++) begin
      exp = mk(7'd3, 32'hA000_0008, 2'b00, i == 2);
      checks++;
      if (i >= pkt_q.size() || pkt_q[i] !== exp) begin
        errors++;
        $display("FAIL fixed beat%0d: got %h expected %h", i,
                 (i < pkt_q.size()) ? pkt_q[i] : 42'h0, exp);
      end
    end
    pkt_q.delete(); cyc_q.delete();
    send_ar(7'd4, 32'h30, 4'd0, 2'b01);
    wait_beats(1, "single");
    exp = mk(7'd4, 32'hA000_000C, 2'b00, 1'b1);
    checks++;
    if (pkt_q.size() < 1 || pkt_q[0] !== exp) begin
      errors++;
      $display("FAIL single beat: got %h expected %h", (pkt_q.size() > 0) ? pkt_q[0] : 42'h0, exp);
    end
  endtask

  task automatic test_backpressure;
    logic [3:0]  pat = 4'b1001;
    logic [41:0] exp;
    int          i = 0;
    pkt_q.delete(); cyc_q.delete();
    send_ar(7'd1, 32'h0, 4'd15, 2'b01);
    while (pkt_q.size() < 16 && i < 400) begin
      @(posedge clk);
      #1 r_ready = pat[i % 4];
      i++;
    end
    r_ready = 1'b1;
    wait_beats(16, "backpressure");
    for (int k = 0; k < 16; k++) begin
      exp = mk(7'd1, 32'hA000_0000 + k, 2'b00, k == 15);
      checks++;
      if (k >= pkt_q.size() || pkt_q[k] !== exp) begin
        errors++;
        $display("FAIL backpressure beat%0d: got %h expected %h", k,
                 (k < pkt_q.size()) ? pkt_q[k] : 42'h0, exp);
      end
    end
    checks += 3;
    if (stall_err != 0) begin errors++; $display("FAIL stall stability: got %0d changes expected 0", stall_err); end
    if (credit_err != 0) begin errors++; $display("FAIL credit limit: got %0d overruns expected 0", credit_err); end
    if (stall_seen == 0) begin errors++; $display("FAIL stall exercised: got 0 stalled cycles expected >0"); end
  endtask

  task automatic test_reset_mid;
    logic [41:0] exp;
    int          t = 0;
    pkt_q.delete(); cyc_q.delete();
    send_ar(7'd6, 32'h0, 4'd7, 2'b01);
    while (pkt_q.size() < 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (pkt_q.size() < 2) begin
      errors++;
      $display("FAIL midreset pre-beats: got %0d expected >=2", pkt_q.size());
    end
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (r_valid !== 1'b0)  begin errors++; $display("FAIL midreset r_valid: got %b expected 0", r_valid); end
    if (ar_ready !== 1'b1) begin errors++; $display("FAIL midreset ar_ready: got %b expected 1", ar_ready); end
    if (mem_cs !== 1'b0)   begin errors++; $display("FAIL midreset mem_cs: got %b expected 0", mem_cs); end
    repeat (2) @(negedge clk);
    pkt_q.delete(); cyc_q.delete();
    rst_n = 1'b1;
    send_ar(7'd2, 32'h40, 4'd0, 2'b01);
    wait_beats(1, "midreset");
    exp = mk(7'd2, 32'hA000_0010, 2'b00, 1'b1);
    checks++;
    if (pkt_q.size() < 1 || pkt_q[0] !== exp) begin
      errors++;
      $display("FAIL midreset new beat: got %h expected %h", (pkt_q.size() > 0) ? pkt_q[0] : 42'h0, exp);
    end
  endtask

  task automatic test_decerr;
    logic [41:0] exp;
    int          cs0;
    int          exp_cs;
    pkt_q.delete(); cyc_q.delete();
    cs0 = cs_cnt;
    send_ar(7'd7, 32'h1000, 4'd1, 2'b01);
    wait_beats(2, "decerr");
    for (int i = 0; i < 2; i++) begin
`ifdef AXI_R_DECERR_EN
      exp = mk(7'd7, 32'h0, 2'b11, i == 1);
`else
      exp = mk(7'd7, 32'hA000_0000 + i, 2'b00, i == 1);
`endif
      checks++;
      if (i >= pkt_q.size() || pkt_q[i] !== exp) begin
        errors++;
        $display("FAIL decerr beat%0d: got %h expected %h", i,
                 (i < pkt_q.size()) ? pkt_q[i] : 42'h0, exp);
      end
    end
`ifdef AXI_R_DECERR_EN
    exp_cs = 0;
`else
    exp_cs = 2;
`endif
    checks++;
    if (cs_cnt - cs0 != exp_cs) begin
      errors++;
      $display("FAIL decerr mem_cs count: got %0d expected %0d", cs_cnt - cs0, exp_cs);
    end
  endtask

  initial begin
    ar_valid = 1'b0;
    ar_id    = '0;
    ar_addr  = '0;
    ar_len   = '0;
    ar_burst = '0;
    r_ready  = 1'b1;
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_single();
    test_backpressure();
    test_reset_mid();
    test_decerr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
